timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: width of period and count datapath.
REQ-002 Parameter PRESC_W, default 4: width of prescale divider.
REQ-003 One clock; reset is asynchronous and active-low: clk input 1 (all state on rising edge), rst_n input 1 (async active-low reset).
REQ-004 start  input  1  request to begin a run; sampled only in IDLE.
REQ-005 stop  input  1  abort the current run; wins over every other event.
REQ-006 mode  input  2  00 ONESHOT, 01 PERIODIC, 10 BOUNCE, 11 treated as ONESHOT.
REQ-007 dir  input  1  1 = count up from 0 to period, 0 = count down from period to 0.
REQ-008 period  input  WIDTH  terminal/start value.
REQ-009 prescale  input  PRESC_W  one count step every prescale+1 RUN cycles.
REQ-010 count_out  output  WIDTH  registered count value.
REQ-011 busy  output  1  high in LOAD and RUN.
REQ-012 done  output  1  one-cycle pulse, high exactly in DONE.
REQ-013 wrap  output  1  registered one-cycle pulse after every terminal tick, in all modes.
REQ-014 dir_out  output  1  current count direction.

Function
REQ-015 FSM states IDLE, LOAD, RUN, DONE shall be implemented.
REQ-016 IDLE: start=1 and stop=0 latches mode, dir, period and prescale, then moves to LOAD; the latched values are used for the rest of the run.
REQ-017 LOAD (one cycle): prescaler cleared; count_out takes start value (0 if dir=1, period if dir=0) at the edge into RUN.
REQ-018 Latency: start sampled at edge N gives busy=1 after N and count_out=start value after N+1.
REQ-019 RUN: prescaler counts 0..prescale and wraps to 0; tick asserted in the cycle the prescaler equals prescale; prescale=0 gives a tick every RUN cycle.
REQ-020 A non-terminal tick steps count_out by 1 toward the target, modulo 2^WIDTH.
REQ-021 Terminal tick is a tick while count_out equals the target (period if counting up, 0 if counting down).
REQ-022 On a terminal tick, ONESHOT holds count_out and moves to DONE.
REQ-023 On a terminal tick, PERIODIC reloads count_out to the start value and stays in RUN.
REQ-024 On a terminal tick, BOUNCE toggles direction and steps count_out one toward the new target in the same edge; if period=0, it toggles only and count_out stays 0.
REQ-025 DONE lasts one cycle, then returns to IDLE; count_out holds.
REQ-026 stop=1 in LOAD or RUN returns to IDLE at the next edge, holds count_out, and produces no done or wrap pulse.
REQ-027 start is ignored outside IDLE; start and stop together in IDLE keep the FSM in IDLE.
REQ-028 period=0: start value equals target, so the first tick is terminal.

Reset
REQ-029 rst_n low immediately forces IDLE, count_out=0, prescaler=0, busy=0, done=0, wrap=0, dir_out=1, and clears the latched configuration.
REQ-030 Reset asserted mid-run aborts the run with no done or wrap pulse; after release, the block waits for a new start.

Structure
REQ-031 Package timer_ctrl_pkg shall hold the state enum (IDLE, LOAD, RUN, DONE) and the mode enum with its encodings.
REQ-032 Sub-module tick_prescaler (ports clk, rst_n, clr, en, prescale, tick) shall implement the divider.
REQ-033 The counter register and FSM reside in timer_ctrl.

Verification
REQ-034 ONESHOT, dir=1, period=3, prescale=0 -> count_out 0,1,2,3; busy drops; done pulses in the cycle after the tick at 3; count_out holds 3.
REQ-035 PERIODIC, dir=0, period=2, prescale=1 -> count_out 2,2,1,1,0,0,2...; wrap pulses once per 6 RUN cycles; done never asserts.
REQ-036 BOUNCE, dir=1, period=2, prescale=0 -> count_out 0,1,2,1,0,1,2...; dir_out toggles at each terminal tick; wrap pulses at each terminal tick.
REQ-037 stop asserted with count_out=1 in RUN -> IDLE next edge, count_out=1 held, no done/wrap; start during RUN has no effect.
REQ-038 rst_n dropped mid-RUN with count_out=5 (WIDTH=4) -> immediate count_out=0, busy=0, IDLE.
REQ-039 period=0, ONESHOT, dir=1 -> first RUN tick is terminal, done pulses, count_out=0.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: FSM state and run-mode encodings shared by the timer.
package timer_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, DONE = 2'b11} state_t;
  typedef enum logic [1:0] {ONESHOT = 2'b00, PERIODIC = 2'b01, BOUNCE = 2'b10, ONESHOT_ALT = 2'b11} mode_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: emits one tick every prescale+1 enabled cycles.
module tick_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] prescale,
  output logic               tick
);
  logic [PRESC_W-1:0] cnt;
  assign tick = en && (cnt == prescale);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled up/down timer with one-shot, periodic and bounce modes.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic               dir,
  input  logic [WIDTH-1:0]   period,
  input  logic [PRESC_W-1:0] prescale,
  output logic [WIDTH-1:0]   count_out,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output logic               dir_out
);
  state_t             state, state_nx;
  mode_t              mode_q;
  logic               dir_q, wrap_q, tick, terminal, run_tick, oneshot;
  logic [WIDTH-1:0]   count_q, period_q, start_val, step_val, bounce_val, term_val;
  logic [PRESC_W-1:0] presc_q;
  tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == LOAD),
    .en      (state == RUN),
    .prescale(presc_q),
    .tick    (tick)
  );
  assign oneshot    = (mode_q == ONESHOT) || (mode_q == ONESHOT_ALT);
  assign terminal   = count_q == (dir_q ? period_q : '0);
  assign run_tick   = (state == RUN) && tick && !stop;
  assign start_val  = dir_q ? '0 : period_q;
  assign step_val   = dir_q ? count_q + 1'b1 : count_q - 1'b1;
  // Bounce reverses at the target and immediately steps away from it.
  assign bounce_val = (period_q == '0) ? count_q : dir_q ? count_q - 1'b1 : count_q + 1'b1;
  assign term_val   = (mode_q == PERIODIC) ? start_val : (mode_q == BOUNCE) ? bounce_val : count_q;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (start && !stop) ? LOAD : IDLE;
      LOAD:    state_nx = stop ? IDLE : RUN;
      RUN:     state_nx = stop ? IDLE : (tick && terminal && oneshot) ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      mode_q   <= ONESHOT;
      dir_q    <= 1'b1;
      period_q <= '0;
      presc_q  <= '0;
      count_q  <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      wrap_q <= run_tick && terminal;
      if (state == IDLE && start && !stop) begin
        mode_q   <= mode_t'(mode);
        dir_q    <= dir;
        period_q <= period;
        presc_q  <= prescale;
      end
      if (state == LOAD && !stop) count_q <= start_val;
      if (run_tick) begin
        count_q <= terminal ? term_val : step_val;
        if (terminal && mode_q == BOUNCE) dir_q <= !dir_q;
      end
    end
  assign count_out = count_q;
  assign busy      = (state == LOAD) || (state == RUN);
  assign done      = state == DONE;
  assign wrap      = wrap_q;
  assign dir_out   = dir_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: scoreboard bench; each expected row is {count_out, busy, done, wrap, dir_out}.
module tb_timer_ctrl;
  logic       clk, rst_n, start, stop, dir, busy, done, wrap, dir_out;
  logic [1:0] mode;
  logic [3:0] period, prescale, count_out;
  logic [7:0] sb[$];
  logic [7:0] e;
  int compared = 0, mismatched = 0;

  timer_ctrl #(.WIDTH(4), .PRESC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .dir(dir),
    .period(period), .prescale(prescale), .count_out(count_out), .busy(busy),
    .done(done), .wrap(wrap), .dir_out(dir_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] v(int c, bit b, bit d, bit w, bit r);
    return {c[3:0], b, d, w, r};
  endfunction

  task automatic go(bit [1:0] m, bit d, int p, int ps);
    mode = m; dir = d; period = p[3:0]; prescale = ps[3:0]; start = 1'b1;
  endtask

  task automatic test_reset();
    sb.push_back(v(0, 0, 0, 0, 1));
    sb.push_back(v(0, 0, 0, 0, 1));
    #3 rst_n = 1'b0;
    #1;
    e = sb.pop_front();
    compared++;
    if ({count_out, busy, done, wrap, dir_out} !== e) begin
      mismatched++;
      $display("FAIL reset_async: got %b expected %b", {count_out, busy, done, wrap, dir_out}, e);
    end
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    if ({count_out, busy, done, wrap, dir_out} !== e) begin
      mismatched++;
      $display("FAIL reset_held: got %b expected %b", {count_out, busy, done, wrap, dir_out}, e);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_oneshot();
    int i = 0;
    foreach (sb[k]) sb.delete(k);
    sb.push_back(v(0, 1, 0, 0, 1));
    sb.push_back(v(0, 1, 0, 0, 1));
    sb.push_back(v(1, 1, 0, 0, 1));
    sb.push_back(v(2, 1, 0, 0, 1));
    sb.push_back(v(3, 1, 0, 0, 1));
    sb.push_back(v(3, 0, 1, 1, 1));
    sb.push_back(v(3, 0, 0, 0, 1));
    go(2'b00, 1'b1, 3, 0);
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      e = sb.pop_front();
      compared++;
      if ({count_out, busy, done, wrap, dir_out} !== e) begin
        mismatched++;
        $display("FAIL oneshot step %0d: got %b expected %b", i, {count_out, busy, done, wrap, dir_out}, e);
      end
      i++;
    end
  endtask

  task automatic test_periodic();
    int i = 0;
    int seq[13] = '{3, 2, 2, 1, 1, 0, 0, 2, 2, 1, 1, 0, 0};
    foreach (seq[k]) sb.push_back(v(seq[k], 1, 0, 0, 0));
    sb.push_back(v(2, 1, 0, 1, 0));
    sb.push_back(v(2, 0, 0, 0, 0));
    sb[7] = v(2, 1, 0, 1, 0);
    go(2'b01, 1'b0, 2, 1);
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      e = sb.pop_front();
      compared++;
      if ({count_out, busy, done, wrap, dir_out} !== e) begin
        mismatched++;
        $display("FAIL periodic step %0d: got %b expected %b", i, {count_out, busy, done, wrap, dir_out}, e);
      end
      stop = (i == 13);
      i++;
    end
  endtask

  task automatic test_bounce();
    int i = 0;
    sb.push_back(v(2, 1, 0, 0, 1));
    sb.push_back(v(0, 1, 0, 0, 1));
    sb.push_back(v(1, 1, 0, 0, 1));
    sb.push_back(v(2, 1, 0, 0, 1));
    sb.push_back(v(1, 1, 0, 1, 0));
    sb.push_back(v(0, 1, 0, 0, 0));
    sb.push_back(v(1, 1, 0, 1, 1));
    sb.push_back(v(2, 1, 0, 0, 1));
    sb.push_back(v(1, 1, 0, 1, 0));
    sb.push_back(v(1, 0, 0, 0, 0));
    go(2'b10, 1'b1, 2, 0);
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      e = sb.pop_front();
      compared++;
      if ({count_out, busy, done, wrap, dir_out} !== e) begin
        mismatched++;
        $display("FAIL bounce step %0d: got %b expected %b", i, {count_out, busy, done, wrap, dir_out}, e);
      end
      stop = (i == 8);
      i++;
    end
  endtask

  task automatic test_stop();
    int i = 0;
    sb.push_back(v(1, 1, 0, 0, 1));
    sb.push_back(v(0, 1, 0, 0, 1));
    sb.push_back(v(1, 1, 0, 0, 1));
    repeat (4) sb.push_back(v(1, 0, 0, 0, 1));
    go(2'b00, 1'b1, 5, 0);
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compared++;
      if ({count_out, busy, done, wrap, dir_out} !== e) begin
        mismatched++;
        $display("FAIL stop step %0d: got %b expected %b", i, {count_out, busy, done, wrap, dir_out}, e);
      end
      start = (i == 1) || (i == 4);
      stop  = (i == 2) || (i == 4);
      if (i == 4) dir = 1'b0;
      i++;
    end
  endtask

  task automatic test_reset_midrun();
    int i = 0;
    sb.push_back(v(1, 1, 0, 0, 1));
    for (int k = 0; k <= 5; k++) sb.push_back(v(k, 1, 0, 0, 1));
    go(2'b01, 1'b1, 9, 0);
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      e = sb.pop_front();
      compared++;
      if ({count_out, busy, done, wrap, dir_out} !== e) begin
        mismatched++;
        $display("FAIL midrun step %0d: got %b expected %b", i, {count_out, busy, done, wrap, dir_out}, e);
      end
      i++;
    end
    repeat (3) sb.push_back(v(0, 0, 0, 0, 1));
    rst_n = 1'b0;
    #1;
    e = sb.pop_front();
    compared++;
    if ({count_out, busy, done, wrap, dir_out} !== e) begin
      mismatched++;
      $display("FAIL midrun_reset: got %b expected %b", {count_out, busy, done, wrap, dir_out}, e);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compared++;
      if ({count_out, busy, done, wrap, dir_out} !== e) begin
        mismatched++;
        $display("FAIL midrun_idle: got %b expected %b", {count_out, busy, done, wrap, dir_out}, e);
      end
    end
  endtask

  task automatic test_period_zero();
    int i = 0;
    sb.push_back(v(0, 1, 0, 0, 1));
    sb.push_back(v(0, 1, 0, 0, 1));
    sb.push_back(v(0, 0, 1, 1, 1));
    sb.push_back(v(0, 0, 0, 0, 1));
    go(2'b00, 1'b1, 0, 0);
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      e = sb.pop_front();
      compared++;
      if ({count_out, busy, done, wrap, dir_out} !== e) begin
        mismatched++;
        $display("FAIL period_zero step %0d: got %b expected %b", i, {count_out, busy, done, wrap, dir_out}, e);
      end
      i++;
    end
  endtask

  task automatic test_mode3_down();
    int i = 0;
    sb.push_back(v(0, 1, 0, 0, 0));
    repeat (3) sb.push_back(v(1, 1, 0, 0, 0));
    repeat (3) sb.push_back(v(0, 1, 0, 0, 0));
    sb.push_back(v(0, 0, 1, 1, 0));
    sb.push_back(v(0, 0, 0, 0, 0));
    go(2'b11, 1'b0, 1, 2);
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      e = sb.pop_front();
      compared++;
      if ({count_out, busy, done, wrap, dir_out} !== e) begin
        mismatched++;
        $display("FAIL mode3_down step %0d: got %b expected %b", i, {count_out, busy, done, wrap, dir_out}, e);
      end
      i++;
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; dir = 1'b0; period = '0; prescale = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_bounce();
    test_stop();
    test_reset_midrun();
    test_period_zero();
    test_mode3_down();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
